imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that fills the processor's instruction memory from a byte stream before execution. Accepts a length header and little-endian instruction bytes over a valid/ready byte interface, assembles 32-bit words and issues one word write per instruction at incrementing word addresses. Holds the core in reset while loading. Sits between the board-level serial/debug receiver and the instruction memory's write port; the fetch path remains the memory's only reader.

## Interface
- ADDR_W, 6, word-address width of instruction memory
- DEPTH, 64, number of 32-bit words in instruction memory

- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a load
- byte_valid  in  1  byte_data holds a valid byte
- byte_data  in  8  incoming stream byte
- byte_ready  out  1  loader can accept a byte this cycle
- wr_en  out  1  instruction-memory write strobe, one cycle per word
- wr_addr  out  ADDR_W  word address of the write
- wr_data  out  32  assembled instruction word
- cpu_hold  out  1  keeps core in reset while high
- done  out  1  load completed successfully
- error  out  1  header length invalid
- word_count  out  ADDR_W+1  words written in current load

## Operation
- Byte transfer occurs on a cycle with byte_valid && byte_ready; no other cycle consumes a byte.
- States: IDLE, LEN, BYTES, WRITE, DONE, ERR.
- IDLE: byte_ready=0, cpu_hold=0. start -> LEN; cpu_hold rises.
- LEN: byte_ready=1. Accepted byte = N (word count). N in 1..DEPTH -> BYTES, word_count cleared; N=0 or N>DEPTH -> ERR.
- BYTES: byte_ready=1. Bytes fill word little-endian: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24]. 4th accepted byte -> WRITE.
- WRITE: byte_ready=0, wr_en=1, wr_addr=word_count[ADDR_W-1:0], wr_data=assembled word; word_count increments at end of cycle. If incremented count == N -> DONE, else BYTES.
- DONE: done=1, cpu_hold=0, word_count holds N. ERR: error=1, cpu_hold=0. Both remain until start or rst.
- start in DONE or ERR: clears done/error, -> LEN. start in LEN/BYTES/WRITE ignored.
- Word addresses always begin at 0; N=DEPTH writes 0..DEPTH-1, no wrap.

## Timing
- Reset values: state IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, error=0, word_count=0, byte counter 0.
- cpu_hold asserts the cycle after start is sampled and deasserts the cycle after entering DONE/ERR.
- Max throughput: 4 bytes per 5 cycles (one WRITE bubble per word). Minimum load of N words: 1 (LEN) + 5N cycles from start to DONE when byte_valid held high.
- wr_en is registered; wr_addr/wr_data stable for the single wr_en cycle.
- Stalls: byte_valid low in LEN/BYTES holds state and partial word indefinitely.
- rst mid-load: immediate return to IDLE, cpu_hold drops, partial word discarded; already-written memory words are not restored.

## Structure
- Shared package imem_pkg: state encoding constants, IMEM_DEPTH=64, IMEM_ADDR_W=6 (used also by instruction memory).
- Sub-module word_assembler: 2-bit byte index + 32-bit shift/assemble register with load/clear inputs and word_full output; FSM and counters in imem_loader.

## Test plan
- Reset, then start, header 0x02, bytes B3 00 00 00 03 21 00 00 -> writes addr 0 = 0x000000B3, addr 1 = 0x00002103; done=1, word_count=2, cpu_hold low after.
- Header 0x00 and separately 0x41 -> ERR, error=1, no wr_en, byte_ready=0 afterward; start recovers to LEN.
- Header 0x40 with 256 bytes, byte_valid always high -> 64 writes addr 0..63, DONE exactly 321 cycles after start; wr_addr never wraps.
- Random byte_valid gaps during a 3-word load -> identical write addresses/data as gapless run; no byte consumed while byte_ready=0 during WRITE.
- rst asserted after 2 bytes of word 1 -> all outputs at reset values same cycle; subsequent start, header 0x01, 4 bytes -> single write to addr 0.
- start pulsed during BYTES -> ignored, load continues; start in DONE -> done clears, new load begins at addr 0.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: loader state encoding and instruction memory geometry, shared with the imem.
package imem_pkg;
    localparam int IMEM_DEPTH  = 64;
    localparam int IMEM_ADDR_W = 6;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_BYTES,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs four little-endian bytes into a 32-bit word.
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_full
);
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    // Shifting right puts the first byte at [7:0] once four bytes are in.
    always_comb begin
        idx_d     = clear ? 2'd0 : load ? idx_q + 2'd1 : idx_q;
        word_d    = clear ? 32'd0 : load ? {din, word_q[31:8]} : word_q;
        word_full = load && idx_q == 2'd3;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end
    assign word = word_q;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a length-prefixed byte stream,
// holding the core in reset while the load is in progress.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);
    state_t            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d, cnt_q, cnt_d;
    logic              byte_ready_q, wr_en_q, cpu_hold_q, done_q, error_q;
    logic              xfer, asm_clear, asm_load, word_full;
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        asm_clear = 1'b0;
        asm_load  = 1'b0;
        xfer      = byte_valid && byte_ready_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                state_d   = start ? S_LEN : state_q;
                asm_clear = start;
            end
            S_LEN: if (xfer) begin
                if (byte_data != 8'd0 && byte_data <= DEPTH_B) begin
                    state_d = S_BYTES;
                    n_d     = byte_data[ADDR_W:0];
                    cnt_d   = '0;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_BYTES: begin
                asm_load = xfer;
                state_d  = word_full ? S_WRITE : S_BYTES;
            end
            S_WRITE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_d == n_q) ? S_DONE : S_BYTES;
            end
            default: state_d = S_IDLE;
        endcase
    end
    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            cnt_q        <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            cnt_q        <= cnt_d;
            byte_ready_q <= state_d == S_LEN || state_d == S_BYTES;
            wr_en_q      <= state_d == S_WRITE;
            cpu_hold_q   <= state_d == S_LEN || state_d == S_BYTES || state_d == S_WRITE;
            done_q       <= state_d == S_DONE;
            error_q      <= state_d == S_ERR;
        end
    end
    word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .load      (asm_load),
        .din       (byte_data),
        .word      (wr_data),
        .word_full (word_full)
    );
    assign byte_ready = byte_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = cnt_q[ADDR_W-1:0];
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of header handling, word assembly, timing and reset.
module tb_imem_loader;
    import imem_pkg::*;
    localparam int AW = IMEM_ADDR_W;
    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready, wr_en, cpu_hold, done, error;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [AW:0]   word_count;
    int total = 0, bad = 0, cyc = 0, t0 = 0;
    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];
    logic [31:0]   w3[3] = '{32'h11223344, 32'hDEADBEEF, 32'h0BADF00D};

    imem_loader dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
        .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write log; a byte must never be offered-ready while a word is being written.
    always @(negedge clk) if (wr_en) begin
        wa.push_back(wr_addr);
        wd.push_back(wr_data);
        chk("ready_in_write", 64'(byte_ready), 64'd0);
    end

    function automatic logic [31:0] pat(input int k);
        pat = {8'hA5, 8'(k), 8'(255 - k), 8'(k * 3)};
    endfunction

    task automatic check_reset_outputs();
        chk("rst_ready", 64'(byte_ready), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_addr", 64'(wr_addr), 64'd0);
        chk("rst_data", 64'(wr_data), 64'd0);
        chk("rst_hold", 64'(cpu_hold), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_count", 64'(word_count), 64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = byte_ready;
            @(negedge clk);
        end
        if (!ok) chk("byte_timeout", 64'd0, 64'd1);
        byte_valid = 1'b0;
        byte_data  = 8'hEE;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        chk("done_seen", 64'(done), 64'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // Two-word load from the example stream
        wa.delete(); wd.delete();
        pulse_start();
        chk("hold_after_start", 64'(cpu_hold), 64'd1);
        chk("ready_in_len", 64'(byte_ready), 64'd1);
        send_byte(8'h02);
        send_word(32'h000000B3, 1'b0);
        send_word(32'h00002103, 1'b0);
        wait_done();
        chk("t1_nwr", 64'(wa.size()), 64'd2);
        chk("t1_a0", 64'(wa[0]), 64'd0);
        chk("t1_d0", 64'(wd[0]), 64'h000000B3);
        chk("t1_a1", 64'(wa[1]), 64'd1);
        chk("t1_d1", 64'(wd[1]), 64'h00002103);
        chk("t1_count", 64'(word_count), 64'd2);
        chk("t1_hold", 64'(cpu_hold), 64'd0);
        chk("t1_ready", 64'(byte_ready), 64'd0);

        // Invalid headers
        wa.delete(); wd.delete();
        pulse_start();
        chk("t2_done_clr", 64'(done), 64'd0);
        send_byte(8'h00);
        chk("t2_err0", 64'(error), 64'd1);
        chk("t2_ready0", 64'(byte_ready), 64'd0);
        chk("t2_hold0", 64'(cpu_hold), 64'd0);
        pulse_start();
        chk("t2_err_clr", 64'(error), 64'd0);
        chk("t2_len_ready", 64'(byte_ready), 64'd1);
        send_byte(8'h41);
        chk("t2_err41", 64'(error), 64'd1);
        chk("t2_ready41", 64'(byte_ready), 64'd0);
        repeat (3) @(negedge clk);
        chk("t2_nwr", 64'(wa.size()), 64'd0);

        // Full-depth load, gapless: 1 + 5*64 cycles
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h40);
        for (int k = 0; k < 64; k++) send_word(pat(k), 1'b0);
        wait_done();
        chk("t3_cycles", 64'(cyc - t0), 64'd321);
        chk("t3_nwr", 64'(wa.size()), 64'd64);
        for (int k = 0; k < 64; k++) begin
            chk("t3_addr", 64'(wa[k]), 64'(k));
            chk("t3_data", 64'(wd[k]), 64'(pat(k)));
        end
        chk("t3_count", 64'(word_count), 64'd64);

        // Three words without and with random valid gaps
        for (int g = 0; g < 2; g++) begin
            wa.delete(); wd.delete();
            pulse_start();
            send_byte(8'h03);
            for (int k = 0; k < 3; k++) send_word(w3[k], g[0]);
            wait_done();
            chk("t4_nwr", 64'(wa.size()), 64'd3);
            for (int k = 0; k < 3; k++) begin
                chk("t4_addr", 64'(wa[k]), 64'(k));
                chk("t4_data", 64'(wd[k]), 64'(w3[k]));
            end
        end

        // Reset mid-word, then a clean one-word load
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h01);
        send_word(32'hCAFE0001, 1'b0);
        wait_done();
        chk("t5_nwr", 64'(wa.size()), 64'd1);
        chk("t5_a0", 64'(wa[0]), 64'd0);
        chk("t5_d0", 64'(wd[0]), 64'hCAFE0001);

        // start during BYTES ignored; start in DONE begins a new load
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h78);
        send_byte(8'h56);
        pulse_start();
        chk("t6_hold", 64'(cpu_hold), 64'd1);
        send_byte(8'h34);
        send_byte(8'h12);
        send_word(32'h9ABCDEF0, 1'b0);
        wait_done();
        chk("t6_nwr", 64'(wa.size()), 64'd2);
        chk("t6_d0", 64'(wd[0]), 64'h12345678);
        chk("t6_a1", 64'(wa[1]), 64'd1);
        chk("t6_d1", 64'(wd[1]), 64'h9ABCDEF0);
        wa.delete(); wd.delete();
        pulse_start();
        chk("t6_done_clr", 64'(done), 64'd0);
        chk("t6_hold2", 64'(cpu_hold), 64'd1);
        send_byte(8'h01);
        send_word(32'h0F0F0F0F, 1'b0);
        wait_done();
        chk("t6_nwr2", 64'(wa.size()), 64'd1);
        chk("t6_a0b", 64'(wa[0]), 64'd0);
        chk("t6_d0b", 64'(wd[0]), 64'h0F0F0F0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
